cozucu_hatti: RTL
=================

# cozucu_hatti

Parametrised decode stage: register file, full RV32I immediate generator, RAW/WAW scoreboard and a registered output slot with valid/ready handshakes on both sides. Sits between the fetch pipeline register and the execute stage. It accepts one instruction per cycle when there is no hazard and presents operands, immediate and destination info one cycle later. An optional write-back forwarding path removes the one-cycle read-after-write stall.

## Interface
- XLEN, 32, data width of registers, operands and immediate (≥32).
- REG_SAYISI, 32, number of architectural registers (power of two, ≤32); AW = $clog2(REG_SAYISI).
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- buyruk_i  input  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], truncated to AW bits.
- sabit_secimi_i  input  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 J, others → 0.
- rd_yaz_i  input  1  instruction writes rd.
- buyruk_gecerli_i  input  1  upstream valid.
- buyruk_hazir_o  output  1  upstream ready.
- geri_yaz_gecerli_i  input  1  write-back strobe.
- geri_yaz_adres_i  input  AW  write-back register.
- geri_yaz_veri_i  input  XLEN  write-back data.
- temizle_i  input  1  flush held instruction.
- cikis_gecerli_o  output  1  downstream valid.
- cikis_hazir_i  input  1  downstream ready.
- reg_a_o, reg_b_o  output  XLEN  rs1/rs2 values.
- sabit_o  output  XLEN  sign-extended immediate.
- rd_adres_o  output  AW  destination register.
- rd_yaz_o  output  1  destination write enable.

## Operation
- Accept = buyruk_gecerli_i & buyruk_hazir_o; buyruk_hazir_o = (!cikis_gecerli_o | cikis_hazir_i) & !hazard & !temizle_i.
- Register file: REG_SAYISI×XLEN. Write on geri_yaz_gecerli_i when the address ≠ 0. Register 0 always reads 0.
- Immediates, sign bit buyruk_i[31] extended to XLEN:
  - I = [31:20].
  - S = {[31:25],[11:7]}.
  - B = {[31],[7],[30:25],[11:8],0}.
  - U = {[31:12],12'b0}.
  - J = {[31],[19:12],[20],[30:21],0}.
- Scoreboard: one busy bit per register; bit 0 is hardwired 0.
  - Set on accept when rd_yaz_i and rd ≠ 0.
  - Cleared on geri_yaz_gecerli_i for that address.
  - Set and clear of the same bit in one cycle: set wins.
  - A write-back to a non-busy register still writes and leaves its bit clear.
- Hazard, per source (rs1 and rs2 are always checked, whatever the format): source ≠ 0, busy, and not cleared by a write-back this cycle. The write-back exception applies only with forwarding; without it a same-cycle write-back still stalls.
- WAW hazard: rd_yaz_i, rd ≠ 0, busy[rd], and no write-back clearing it this cycle. The write-back exception applies in both modes.
- temizle_i: on the next edge cikis_gecerli_o ← 0. If the held instruction has rd_yaz_o, its busy bit is cleared. No accept occurs in that cycle. Instructions already past this stage are not affected.

## Timing
- Latency 1: the instruction accepted at edge N appears on the outputs after edge N with cikis_gecerli_o = 1.
- Outputs are held stable while cikis_gecerli_o & !cikis_hazir_i.
- When downstream accepts with no new accept in the same cycle, cikis_gecerli_o drops to 0.
- Operands are sampled at the accept edge; later write-backs do not alter the held operands.
- Back-to-back throughput is 1 per cycle when there are no hazards.
- Reset (asynchronous, mid-operation allowed): all registers, scoreboard bits and outputs are 0, including cikis_gecerli_o, reg_a_o, reg_b_o, sabit_o, rd_adres_o and rd_yaz_o. After release, buyruk_hazir_o = 1 unless cikis_hazir_i is irrelevant, i.e. it depends only on the hazard logic.

## Configuration
- COZUCU_YONLENDIRME_EN defined: a same-cycle write-back to a source register clears that RAW hazard, and the operand mux selects geri_yaz_veri_i (address ≠ 0). The dependent instruction is accepted in the write-back cycle.
- COZUCU_YONLENDIRME_EN undefined: no bypass. The dependent instruction stalls through the write-back cycle and is accepted one cycle later, reading the register file.

## Test plan
- Reset, then write x5 = 0x0000_1234; accept "addi x6,x5,-1" (I, imm 0xFFF) → reg_a_o = 0x1234, sabit_o = 0xFFFF_FFFF, rd_adres_o = 6, one cycle later.
- Immediate decode, all five formats: 0x8000_0000-style patterns verify sign fill; B and J bit 0 = 0; U low 12 bits = 0; select 101 → sabit_o = 0.
- RAW: accept an instruction writing x7, then one reading x7 → buyruk_hazir_o = 0 until write-back of 0xDEAD_BEEF.
  - With the macro: accepted in the write-back cycle with reg_a_o = 0xDEAD_BEEF.
  - Without the macro: accepted one cycle later with the same value.
- Backpressure: hold cikis_hazir_i = 0 for 3 cycles → outputs stable and buyruk_hazir_o = 0; release → next instruction accepted the same cycle.
- Flush: hold an instruction writing x9 and pulse temizle_i → cikis_gecerli_o = 0 and busy[9] cleared; a subsequent x9 reader is accepted without stall.
- Async reset asserted mid-stall → outputs and busy bits 0 immediately; x0 reads 0 even after a write-back to x0.

Source files
------------

// File: rtl/cozucu_hatti_if.sv
// Decode-stage bus bundle: fetch-side handshake, write-back port, flush and
// the registered execute-side slot. Clock and reset are kept outside.
// slave  = the decode stage's view, master = the surrounding pipeline's view.
interface cozucu_hatti_if #(
    parameter int XLEN       = 32,
    parameter int REG_SAYISI = 32
);
    localparam int AW = $clog2(REG_SAYISI);

    logic [31:0]      buyruk_i;
    logic [2:0]       sabit_secimi_i;
    logic             rd_yaz_i;
    logic             buyruk_gecerli_i;
    logic             buyruk_hazir_o;
    logic             geri_yaz_gecerli_i;
    logic [AW-1:0]    geri_yaz_adres_i;
    logic [XLEN-1:0]  geri_yaz_veri_i;
    logic             temizle_i;
    logic             cikis_gecerli_o;
    logic             cikis_hazir_i;
    logic [XLEN-1:0]  reg_a_o;
    logic [XLEN-1:0]  reg_b_o;
    logic [XLEN-1:0]  sabit_o;
    logic [AW-1:0]    rd_adres_o;
    logic             rd_yaz_o;

    modport slave (
        input  buyruk_i, sabit_secimi_i, rd_yaz_i, buyruk_gecerli_i,
        input  geri_yaz_gecerli_i, geri_yaz_adres_i, geri_yaz_veri_i,
        input  temizle_i, cikis_hazir_i,
        output buyruk_hazir_o, cikis_gecerli_o, reg_a_o, reg_b_o,
        output sabit_o, rd_adres_o, rd_yaz_o
    );

    modport master (
        output buyruk_i, sabit_secimi_i, rd_yaz_i, buyruk_gecerli_i,
        output geri_yaz_gecerli_i, geri_yaz_adres_i, geri_yaz_veri_i,
        output temizle_i, cikis_hazir_i,
        input  buyruk_hazir_o, cikis_gecerli_o, reg_a_o, reg_b_o,
        input  sabit_o, rd_adres_o, rd_yaz_o
    );
endinterface

// File: rtl/cozucu_hatti.sv
// cozucu_hatti: RV32I decode stage. Register file, immediate generator,
// RAW/WAW busy-bit scoreboard and a one-entry registered output slot.
// Optional feature: define COZUCU_YONLENDIRME_EN to bypass a same-cycle
// write-back straight into the operands (removes the one-cycle RAW stall).
module cozucu_hatti #(
    parameter int XLEN       = 32,
    parameter int REG_SAYISI = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    cozucu_hatti_if.slave  bus
);
    localparam int AW = $clog2(REG_SAYISI);

    logic [31:0]           buyruk;
    logic [AW-1:0]         rs1_adres, rs2_adres, rd_adres;
    logic [XLEN-1:0]       regs_q [REG_SAYISI];
    logic [REG_SAYISI-1:0] busy_q, busy_d;
    logic [XLEN-1:0]       rf_a, rf_b, op_a, op_b, sabit;
    logic                  raw_a, raw_b, waw, wb_rd, hazard, hazir, kabul;
    logic                  temizle_sil;
    logic                  unused_buyruk_alanlari;
`ifdef COZUCU_YONLENDIRME_EN
    logic                  wb_a, wb_b;
`endif

    logic                  cikis_gecerli_q, cikis_gecerli_d;
    logic [XLEN-1:0]       reg_a_q, reg_a_d, reg_b_q, reg_b_d, sabit_q, sabit_d;
    logic [AW-1:0]         rd_adres_q, rd_adres_d;
    logic                  rd_yaz_q, rd_yaz_d;

    assign buyruk    = bus.buyruk_i;
    assign rs1_adres = buyruk[15 +: AW];
    assign rs2_adres = buyruk[20 +: AW];
    assign rd_adres  = buyruk[7 +: AW];
    // opcode and funct3 are the execute stage's business
    assign unused_buyruk_alanlari = ^{buyruk[6:0], buyruk[14:12]};

    // x0 reads as zero regardless of what the array holds
    assign rf_a = (rs1_adres == '0) ? '0 : regs_q[rs1_adres];
    assign rf_b = (rs2_adres == '0) ? '0 : regs_q[rs2_adres];

    // Hazard detection and operand selection (bypass only when enabled)
    always_comb begin
        wb_rd = bus.geri_yaz_gecerli_i && (bus.geri_yaz_adres_i == rd_adres);
        waw   = bus.rd_yaz_i && (rd_adres != '0) && busy_q[rd_adres] && !wb_rd;
`ifdef COZUCU_YONLENDIRME_EN
        wb_a  = bus.geri_yaz_gecerli_i && (bus.geri_yaz_adres_i == rs1_adres);
        wb_b  = bus.geri_yaz_gecerli_i && (bus.geri_yaz_adres_i == rs2_adres);
        raw_a = (rs1_adres != '0) && busy_q[rs1_adres] && !wb_a;
        raw_b = (rs2_adres != '0) && busy_q[rs2_adres] && !wb_b;
        op_a  = (wb_a && rs1_adres != '0) ? bus.geri_yaz_veri_i : rf_a;
        op_b  = (wb_b && rs2_adres != '0) ? bus.geri_yaz_veri_i : rf_b;
`else
        raw_a = (rs1_adres != '0) && busy_q[rs1_adres];
        raw_b = (rs2_adres != '0) && busy_q[rs2_adres];
        op_a  = rf_a;
        op_b  = rf_b;
`endif
        hazard = raw_a || raw_b || waw;
    end

    assign hazir       = (!cikis_gecerli_q || bus.cikis_hazir_i) && !hazard && !bus.temizle_i;
    assign kabul       = bus.buyruk_gecerli_i && hazir;
    assign temizle_sil = bus.temizle_i && cikis_gecerli_q && rd_yaz_q;

    // Immediate generator: assemble the field, then sign-extend to XLEN
    always_comb begin
        sabit = '0;
        case (bus.sabit_secimi_i)
            3'b000:  sabit = XLEN'($signed(buyruk[31:20]));
            3'b001:  sabit = XLEN'($signed({buyruk[31:25], buyruk[11:7]}));
            3'b010:  sabit = XLEN'($signed({buyruk[31], buyruk[7], buyruk[30:25],
                                             buyruk[11:8], 1'b0}));
            3'b011:  sabit = XLEN'($signed({buyruk[31:12], 12'b0}));
            3'b100:  sabit = XLEN'($signed({buyruk[31], buyruk[19:12], buyruk[20],
                                             buyruk[30:21], 1'b0}));
            default: sabit = '0;
        endcase
    end

    // Scoreboard next state: set on accepted rd write beats any same-cycle clear
    genvar gi;
    assign busy_d[0] = 1'b0;
    generate
        for (gi = 1; gi < REG_SAYISI; gi++) begin : g_busy
            logic kur, sil;
            assign kur = kabul && bus.rd_yaz_i && (rd_adres == AW'(gi));
            assign sil = (bus.geri_yaz_gecerli_i && bus.geri_yaz_adres_i == AW'(gi))
                      || (temizle_sil && rd_adres_q == AW'(gi));
            assign busy_d[gi] = kur || (busy_q[gi] && !sil);
        end
    endgenerate

    // Output slot next state: load on accept, empty on flush or downstream take
    always_comb begin
        cikis_gecerli_d = cikis_gecerli_q;
        reg_a_d         = reg_a_q;
        reg_b_d         = reg_b_q;
        sabit_d         = sabit_q;
        rd_adres_d      = rd_adres_q;
        rd_yaz_d        = rd_yaz_q;
        if (kabul) begin
            cikis_gecerli_d = 1'b1;
            reg_a_d         = op_a;
            reg_b_d         = op_b;
            sabit_d         = sabit;
            rd_adres_d      = rd_adres;
            rd_yaz_d        = bus.rd_yaz_i;
        end else if (bus.temizle_i || (cikis_gecerli_q && bus.cikis_hazir_i)) begin
            cikis_gecerli_d = 1'b0;
        end
    end

    // Register file write port; x0 is never written
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_SAYISI; i++) regs_q[i] <= '0;
        end else if (bus.geri_yaz_gecerli_i && bus.geri_yaz_adres_i != '0) begin
            regs_q[bus.geri_yaz_adres_i] <= bus.geri_yaz_veri_i;
        end
    end

    // Scoreboard and output slot state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q          <= '0;
            cikis_gecerli_q <= 1'b0;
            reg_a_q         <= '0;
            reg_b_q         <= '0;
            sabit_q         <= '0;
            rd_adres_q      <= '0;
            rd_yaz_q        <= 1'b0;
        end else begin
            busy_q          <= busy_d;
            cikis_gecerli_q <= cikis_gecerli_d;
            reg_a_q         <= reg_a_d;
            reg_b_q         <= reg_b_d;
            sabit_q         <= sabit_d;
            rd_adres_q      <= rd_adres_d;
            rd_yaz_q        <= rd_yaz_d;
        end
    end

    assign bus.buyruk_hazir_o  = hazir;
    assign bus.cikis_gecerli_o = cikis_gecerli_q;
    assign bus.reg_a_o         = reg_a_q;
    assign bus.reg_b_o         = reg_b_q;
    assign bus.sabit_o         = sabit_q;
    assign bus.rd_adres_o      = rd_adres_q;
    assign bus.rd_yaz_o        = rd_yaz_q;
endmodule
